fetch_hazard_controller: RTL and testbench

- Stall, flush and halt sequencer for the no-forwarding 5-stage MIPS-lite pipeline.
- Holds a per-register write scoreboard for in-flight producers and compares it against the sources of the instruction in ID.
- Drives hazardDetected to the program counter and IF/ID, bubble/flush controls to the ID/EX and IF/ID registers, and haltSignal to the fetch stage.
- Owns the RUN/DRAIN/HALTED halt state machine and a stall-cycle performance counter.

---
 rtl/mips_pkg.sv | 12 +
 rtl/reg_scoreboard.sv | 41 ++++
 rtl/fetch_hazard_controller.sv | 96 +++++++++
 tb/tb_fetch_hazard_controller.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and widths for the MIPS-lite pipeline control blocks.
package mips_pkg;

  localparam int REGADDRWIDTH = 5;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } HaltState_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register countdown of cycles until an in-flight producer's write is readable.
module reg_scoreboard
  import mips_pkg::*;
#(
  parameter int REGCOUNT   = 32,
  parameter int WB_LATENCY = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_en,
  input  logic [REGADDRWIDTH-1:0] load_idx,
  input  logic [REGADDRWIDTH-1:0] rd_idx_a,
  input  logic [REGADDRWIDTH-1:0] rd_idx_b,
  output logic                    busy_a,
  output logic                    busy_b
);

  localparam int CW = $clog2(WB_LATENCY + 1);

  logic [CW-1:0] cnt [REGCOUNT];

  // r0 is never loaded, so its counter stays zero and it never reads busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < REGCOUNT; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < REGCOUNT; i++) begin
        if (load_en && (load_idx != '0) && (REGADDRWIDTH'(i) == load_idx))
          cnt[i] <= CW'(WB_LATENCY);
        else if (cnt[i] != '0)
          cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end

  always_comb begin
    busy_a = (rd_idx_a != '0) && (cnt[rd_idx_a] != '0);
    busy_b = (rd_idx_b != '0) && (cnt[rd_idx_b] != '0);
  end

endmodule

// File: rtl/fetch_hazard_controller.sv
// Stall, flush and halt sequencing for the no-forwarding 5-stage pipeline.
module fetch_hazard_controller
  import mips_pkg::*;
#(
  parameter int REGCOUNT     = 32,
  parameter int WB_LATENCY   = 3,
  parameter int DRAIN_CYCLES = 3,
  parameter int STATWIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    idValid,
  input  logic [REGADDRWIDTH-1:0] idRs,
  input  logic [REGADDRWIDTH-1:0] idRt,
  input  logic                    idUsesRs,
  input  logic                    idUsesRt,
  input  logic                    idWritesReg,
  input  logic [REGADDRWIDTH-1:0] idDest,
  input  logic                    idIsHalt,
  input  logic                    branchTaken,
  output logic                    hazardDetected,
  output logic                    bubbleIdEx,
  output logic                    flushIfId,
  output logic                    haltSignal,
  output HaltState_t              haltState,
  output logic [STATWIDTH-1:0]    stallCount
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  logic          busy_rs;
  logic          busy_rt;
  logic          raw_hazard;
  logic          issue;
  logic [DW-1:0] drain_cnt;

  reg_scoreboard #(
    .REGCOUNT   (REGCOUNT),
    .WB_LATENCY (WB_LATENCY)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .load_en  (issue & idWritesReg),
    .load_idx (idDest),
    .rd_idx_a (idRs),
    .rd_idx_b (idRt),
    .busy_a   (busy_rs),
    .busy_b   (busy_rt)
  );

  always_comb begin
    raw_hazard     = idValid & ((idUsesRs & busy_rs) | (idUsesRt & busy_rt));
    hazardDetected = raw_hazard & ~branchTaken & (haltState == RUN);
    issue          = idValid & ~hazardDetected & ~branchTaken & (haltState == RUN);
    bubbleIdEx     = hazardDetected | branchTaken | (haltState != RUN);
    flushIfId      = branchTaken;
    haltSignal     = (haltState != RUN);
  end

  // drain_cnt holds DRAIN_CYCLES in the first DRAIN cycle; leaving when it is
  // about to reach 1 makes HALTED visible DRAIN_CYCLES cycles after HALT issues.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      haltState <= RUN;
      drain_cnt <= '0;
    end else begin
      case (haltState)
        RUN: begin
          if (issue && idIsHalt) begin
            haltState <= DRAIN;
            drain_cnt <= DW'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          if (branchTaken) begin
            haltState <= RUN;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
            if (drain_cnt <= DW'(2)) haltState <= HALTED;
          end
        end
        HALTED:  haltState <= HALTED;
        default: haltState <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stallCount <= '0;
    else if (hazardDetected && (stallCount != '1))
      stallCount <= stallCount + STATWIDTH'(1);
  end

endmodule

// File: tb/tb_fetch_hazard_controller.sv
// Directed checks of stall, flush, halt and reset behaviour of the hazard controller.
module tb_fetch_hazard_controller;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       idValid, idUsesRs, idUsesRt, idWritesReg, idIsHalt, branchTaken;
  logic [4:0] idRs, idRt, idDest;
  logic       hazardDetected, bubbleIdEx, flushIfId, haltSignal;
  HaltState_t haltState;
  logic [1:0] stallCount;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  // A 2-bit stall counter lets the bench reach saturation in a few stalls.
  fetch_hazard_controller #(
    .REGCOUNT     (32),
    .WB_LATENCY   (3),
    .DRAIN_CYCLES (3),
    .STATWIDTH    (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .idValid        (idValid),
    .idRs           (idRs),
    .idRt           (idRt),
    .idUsesRs       (idUsesRs),
    .idUsesRt       (idUsesRt),
    .idWritesReg    (idWritesReg),
    .idDest         (idDest),
    .idIsHalt       (idIsHalt),
    .branchTaken    (branchTaken),
    .hazardDetected (hazardDetected),
    .bubbleIdEx     (bubbleIdEx),
    .flushIfId      (flushIfId),
    .haltSignal     (haltSignal),
    .haltState      (haltState),
    .stallCount     (stallCount)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  // Drive one ID-stage instruction; caller is positioned just after a rising edge.
  task automatic drive(input logic v, input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt,
                       input logic wr, input logic [4:0] dst,
                       input logic halt, input logic br);
    idValid = v; idRs = rs; idUsesRs = urs; idRt = rt; idUsesRt = urt;
    idWritesReg = wr; idDest = dst; idIsHalt = halt; branchTaken = br;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      next_cycle();
    end
  endtask

  task automatic check_outs(input string tag, input logic hz, input logic bub,
                            input logic fl, input logic hs, input logic [1:0] st);
    check({tag, ".hazard"}, 32'(hazardDetected), 32'(hz));
    check({tag, ".bubble"}, 32'(bubbleIdEx), 32'(bub));
    check({tag, ".flush"}, 32'(flushIfId), 32'(fl));
    check({tag, ".halt"}, 32'(haltSignal), 32'(hs));
    check({tag, ".state"}, 32'(haltState), 32'(st));
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    next_cycle();
    next_cycle();
    check_outs("rst", 0, 0, 0, 0, 2'd0);
    check("rst.stall", 32'(stallCount), 32'd0);
    reset = 1'b0;
    next_cycle();

    // Adjacent RAW on r3: three stall cycles, issue on the fourth.
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    check_outs("raw.t0", 0, 0, 0, 0, 2'd0);
    next_cycle();
    for (int unsigned k = 1; k <= 3; k++) begin
      drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
      check_outs($sformatf("raw.t%0d", k), 1, 1, 0, 0, 2'd0);
      next_cycle();
    end
    drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
    check_outs("raw.t4", 0, 0, 0, 0, 2'd0);
    check("raw.stall", 32'(stallCount), 32'd3);
    next_cycle();
    idle(3);

    // r0 is never tracked: write r0 then read it on both ports.
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    check_outs("r0", 0, 0, 0, 0, 2'd0);
    next_cycle();
    check("r0.stall", 32'(stallCount), 32'd3);
    idle(3);

    // Stall on r5, then a taken branch discards the consumer (which writes r6).
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 5'd5, 1'b0, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
    check("br.t1.hazard", 32'(hazardDetected), 32'd1);
    next_cycle();
    drive(1'b1, 5'd5, 1'b0, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b1);
    check_outs("br.t2", 0, 1, 1, 0, 2'd0);
    next_cycle();
    drive(1'b1, 5'd6, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("br.r6_free", 32'(hazardDetected), 32'd0);
    // Fourth stall overall: the 2-bit counter must hold at 3.
    check("br.stall_sat", 32'(stallCount), 32'd3);
    next_cycle();
    idle(3);

    // HALT cancelled by an older taken branch in the first DRAIN cycle.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    next_cycle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    check_outs("hcan.t1", 0, 1, 1, 1, 2'd1);
    next_cycle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    check_outs("hcan.t2", 0, 0, 0, 0, 2'd0);
    next_cycle();

    // HALT runs to completion: DRAIN at t+1, HALTED from t+3, sticky.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    next_cycle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    check_outs("halt.t1", 0, 1, 0, 1, 2'd1);
    next_cycle();
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    check_outs("halt.t2", 0, 1, 0, 1, 2'd1);
    next_cycle();
    check_outs("halt.t3", 0, 1, 0, 1, 2'd2);
    idle(4);
    check_outs("halt.t7", 0, 1, 0, 1, 2'd2);

    // Leave HALTED via reset, then stall on r7 and reset mid-stall.
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    next_cycle();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("mid.t1.hazard", 32'(hazardDetected), 32'd1);
    next_cycle();
    check("mid.t2.stall", 32'(stallCount), 32'd1);
    reset = 1'b1;
    #1;
    check_outs("mid.rst", 0, 0, 0, 0, 2'd0);
    check("mid.rst.stall", 32'(stallCount), 32'd0);
    next_cycle();
    reset = 1'b0;
    next_cycle();
    drive(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    check_outs("post.rst", 0, 0, 0, 0, 2'd0);
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
